multicycle_control: RTL and testbench

Finite-state control unit for the multi-cycle ARM processor. It sequences the shared datapath (a single memory port, a single ALU, and the architectural registers) through fetch, decode, execute, memory and writeback phases for one instruction at a time. It evaluates the condition field against an internal NZCV flag register and stretches the memory phases on a ready handshake. It replaces the single-cycle control path in the top-level core.

---
 rtl/multicycle_control.sv | 213 +++++++++++++++++++++
 tb/tb_multicycle_control.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control.sv
// Multi-cycle ARM control unit. It steps the shared memory/ALU/register datapath
// through fetch, decode, execute, memory and writeback for one instruction at a time.
// It also holds the NZCV flag register and stretches memory phases until MemReady.
module multicycle_control (
    input  logic        CLK,
    input  logic        RESETn,
    input  logic [31:0] Instr,
    input  logic [3:0]  ALUFlags,
    input  logic        MemReady,
    output logic        PCWrite,
    output logic        IRWrite,
    output logic        AdrSrc,
    output logic        MemWrite,
    output logic        RegWrite,
    output logic        ALUSrcA,
    output logic [1:0]  ALUSrcB,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  ImmSrc,
    output logic [1:0]  RegSrc,
    output logic [1:0]  ALUControl,
    output logic [3:0]  Flags,
    output logic [3:0]  State
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t      r_state;
    state_t      w_next_state;
    logic [3:0]  r_flags;
    logic [3:0]  w_flags_next;
    logic        w_flags_we;
    logic        w_cond_ex;
    logic        w_pcw_raw;
    logic        w_irw_raw;
    logic        w_memw_raw;
    logic        w_regw_raw;
    logic [1:0]  w_dp_alu;

    // Instruction fields
    logic [1:0]  w_op;
    logic [3:0]  w_cmd;
    logic        w_i;
    logic        w_s;
    logic        w_u;
    logic        w_l;
    logic        w_rd15;
    logic        w_is_cmp;
    logic        w_logical;
    logic        w_unused;

    assign w_op      = Instr[27:26];
    assign w_i       = Instr[25];
    assign w_cmd     = Instr[24:21];
    assign w_s       = Instr[20];
    assign w_u       = Instr[23];
    assign w_l       = Instr[20];
    assign w_rd15    = (Instr[15:12] == 4'hF);
    assign w_is_cmp  = (w_cmd[3:1] == 3'b101);
    assign w_logical = (w_cmd == 4'b0000) || (w_cmd == 4'b1100);
    assign w_unused  = &{1'b0, Instr[19:16], Instr[11:0]};

    // Immediate format and register-port selects depend only on the opcode class
    assign ImmSrc = (w_op == 2'b01) ? 2'b01 : (w_op == 2'b10) ? 2'b10 : 2'b00;
    assign RegSrc = {(w_op == 2'b01) && !w_l, (w_op == 2'b10)};

    assign Flags = r_flags;
    assign State = r_state;

    // Write strobes are held off for as long as reset is asserted
    assign PCWrite  = w_pcw_raw  & RESETn;
    assign IRWrite  = w_irw_raw  & RESETn;
    assign MemWrite = w_memw_raw & RESETn;
    assign RegWrite = w_regw_raw & RESETn;

    // ARM condition evaluation against the registered flags {N,Z,C,V}
    always_comb begin
        w_cond_ex = 1'b0;
        case (Instr[31:28])
            4'b0000: w_cond_ex = r_flags[2];
            4'b0001: w_cond_ex = !r_flags[2];
            4'b0010: w_cond_ex = r_flags[1];
            4'b0011: w_cond_ex = !r_flags[1];
            4'b0100: w_cond_ex = r_flags[3];
            4'b0101: w_cond_ex = !r_flags[3];
            4'b0110: w_cond_ex = r_flags[0];
            4'b0111: w_cond_ex = !r_flags[0];
            4'b1000: w_cond_ex = r_flags[1] && !r_flags[2];
            4'b1001: w_cond_ex = !r_flags[1] || r_flags[2];
            4'b1010: w_cond_ex = (r_flags[3] == r_flags[0]);
            4'b1011: w_cond_ex = (r_flags[3] != r_flags[0]);
            4'b1100: w_cond_ex = !r_flags[2] && (r_flags[3] == r_flags[0]);
            4'b1101: w_cond_ex = r_flags[2] || (r_flags[3] != r_flags[0]);
            4'b1110: w_cond_ex = 1'b1;
            default: w_cond_ex = 1'b0;
        endcase
    end

    // ALU operation for data-processing commands; compares map onto SUB/ADD
    always_comb begin
        w_dp_alu = 2'b00;
        case (w_cmd)
            4'b0000: w_dp_alu = 2'b10;
            4'b0010: w_dp_alu = 2'b01;
            4'b0100: w_dp_alu = 2'b00;
            4'b1100: w_dp_alu = 2'b11;
            4'b1010: w_dp_alu = 2'b01;
            4'b1011: w_dp_alu = 2'b00;
            default: w_dp_alu = 2'b00;
        endcase
    end

    // State and flag registers
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            r_state <= S_FETCH;
            r_flags <= 4'b0000;
        end else begin
            r_state <= w_next_state;
            if (w_flags_we) begin
                r_flags <= w_flags_next;
            end
        end
    end

    // Next-state and per-state datapath controls; everything not driven is 0
    always_comb begin
        w_next_state = S_FETCH;
        w_pcw_raw    = 1'b0;
        w_irw_raw    = 1'b0;
        w_memw_raw   = 1'b0;
        w_regw_raw   = 1'b0;
        AdrSrc       = 1'b0;
        ALUSrcA      = 1'b0;
        ALUSrcB      = 2'b00;
        ResultSrc    = 2'b00;
        ALUControl   = 2'b00;
        w_flags_we   = 1'b0;
        w_flags_next = ALUFlags;
        case (r_state)
            S_FETCH: begin
                ALUSrcA      = 1'b1;
                ALUSrcB      = 2'b10;
                ResultSrc    = 2'b10;
                w_pcw_raw    = MemReady;
                w_irw_raw    = MemReady;
                w_next_state = MemReady ? S_DECODE : S_FETCH;
            end
            S_DECODE: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                if (!w_cond_ex || (w_op == 2'b11)) begin
                    w_next_state = S_FETCH;
                end else if (w_op == 2'b01) begin
                    w_next_state = S_MEMADR;
                end else if (w_op == 2'b10) begin
                    w_next_state = S_BRANCH;
                end else begin
                    w_next_state = w_i ? S_EXECI : S_EXECR;
                end
            end
            S_MEMADR: begin
                ALUSrcB      = 2'b01;
                ALUControl   = w_u ? 2'b00 : 2'b01;
                w_next_state = w_l ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                AdrSrc       = 1'b1;
                w_next_state = MemReady ? S_MEMWB : S_MEMRD;
            end
            S_MEMWB: begin
                ResultSrc  = 2'b01;
                w_regw_raw = !w_rd15;
                w_pcw_raw  = w_rd15;
            end
            S_MEMWR: begin
                AdrSrc       = 1'b1;
                w_memw_raw   = 1'b1;
                w_next_state = MemReady ? S_FETCH : S_MEMWR;
            end
            S_EXECR, S_EXECI: begin
                ALUSrcB      = (r_state == S_EXECI) ? 2'b01 : 2'b00;
                ALUControl   = w_dp_alu;
                w_flags_we   = w_s || w_is_cmp;
                w_flags_next = w_logical ? {ALUFlags[3:2], r_flags[1:0]} : ALUFlags;
                w_next_state = w_is_cmp ? S_FETCH : S_ALUWB;
            end
            S_ALUWB: begin
                w_regw_raw = !w_rd15;
                w_pcw_raw  = w_rd15;
            end
            S_BRANCH: begin
                ALUSrcB   = 2'b01;
                ResultSrc = 2'b10;
                w_pcw_raw = 1'b1;
            end
            default: begin
                w_next_state = S_FETCH;
            end
        endcase
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Testbench for multicycle_control. An instruction-level model expands each
// instruction into its expected cycle trace; the bench drives that trace and
// compares every cycle's outputs.
module tb_multicycle_control;

    logic        CLK = 1'b0;
    logic        RESETn = 1'b0;
    logic [31:0] Instr = 32'h0;
    logic [3:0]  ALUFlags = 4'h0;
    logic        MemReady = 1'b1;
    logic        PCWrite, IRWrite, AdrSrc, MemWrite, RegWrite, ALUSrcA;
    logic [1:0]  ALUSrcB, ResultSrc, ImmSrc, RegSrc, ALUControl;
    logic [3:0]  Flags, State;

    multicycle_control dut (
        .CLK(CLK), .RESETn(RESETn), .Instr(Instr), .ALUFlags(ALUFlags),
        .MemReady(MemReady), .PCWrite(PCWrite), .IRWrite(IRWrite),
        .AdrSrc(AdrSrc), .MemWrite(MemWrite), .RegWrite(RegWrite),
        .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ResultSrc(ResultSrc),
        .ImmSrc(ImmSrc), .RegSrc(RegSrc), .ALUControl(ALUControl),
        .Flags(Flags), .State(State)
    );

    always #5 CLK = ~CLK;

    // One expected cycle: stimulus to apply and outputs to see
    typedef struct {
        logic [3:0] st;
        logic       pcw, irw, memw, regw, adr, srca;
        logic [1:0] srcb, res, alu;
        logic       mr;
        logic [3:0] af;
        logic [3:0] fl;
    } cyc_t;

    cyc_t       q[$];
    logic [3:0] m_flags = 4'h0;
    int         checks = 0;
    int         failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic bit cond_pass(input logic [3:0] c, input logic [3:0] f);
        bit n = f[3];
        bit z = f[2];
        bit cy = f[1];
        bit v = f[0];
        case (c)
            4'd0:  return z;
            4'd1:  return !z;
            4'd2:  return cy;
            4'd3:  return !cy;
            4'd4:  return n;
            4'd5:  return !n;
            4'd6:  return v;
            4'd7:  return !v;
            4'd8:  return cy && !z;
            4'd9:  return !cy || z;
            4'd10: return n == v;
            4'd11: return n != v;
            4'd12: return !z && (n == v);
            4'd13: return z || (n != v);
            4'd14: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    function automatic void push(input logic [3:0] st, input logic pcw, input logic irw,
                                 input logic memw, input logic regw, input logic adr,
                                 input logic srca, input logic [1:0] srcb, input logic [1:0] res,
                                 input logic [1:0] alu, input logic mr, input logic [3:0] af);
        cyc_t c;
        c.st = st; c.pcw = pcw; c.irw = irw; c.memw = memw; c.regw = regw;
        c.adr = adr; c.srca = srca; c.srcb = srcb; c.res = res; c.alu = alu;
        c.mr = mr; c.af = af; c.fl = m_flags;
        q.push_back(c);
    endfunction

    function automatic logic [3:0] rnd4();
        return 4'($urandom_range(0, 15));
    endfunction

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    // Expand one instruction into its expected cycle trace, updating the flag model
    function automatic void build(input logic [31:0] ins, input int fw, input int mw,
                                  input logic [3:0] exec_af);
        logic [1:0] op;
        logic [3:0] cmd;
        logic       rd15, is_cmp, logical;
        logic [1:0] alu;
        op   = ins[27:26];
        cmd  = ins[24:21];
        rd15 = (ins[15:12] == 4'hF);
        q.delete();
        for (int k = 0; k < fw; k++) push(4'd0, 0, 0, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 1'b0, rnd4());
        push(4'd0, 1, 1, 0, 0, 0, 1, 2'b10, 2'b10, 2'b00, 1'b1, rnd4());
        push(4'd1, 0, 0, 0, 0, 0, 1, 2'b10, 2'b00, 2'b00, rbit(), rnd4());
        if (!cond_pass(ins[31:28], m_flags) || op == 2'b11) return;
        if (op == 2'b01) begin
            push(4'd2, 0, 0, 0, 0, 0, 0, 2'b01, 2'b00, ins[23] ? 2'b00 : 2'b01, rbit(), rnd4());
            if (ins[20]) begin
                for (int k = 0; k < mw; k++) push(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b0, rnd4());
                push(4'd3, 0, 0, 0, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b1, rnd4());
                push(4'd4, rd15, 0, 0, !rd15, 0, 0, 2'b00, 2'b01, 2'b00, rbit(), rnd4());
            end else begin
                for (int k = 0; k < mw; k++) push(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b0, rnd4());
                push(4'd5, 0, 0, 1, 0, 1, 0, 2'b00, 2'b00, 2'b00, 1'b1, rnd4());
            end
        end else if (op == 2'b10) begin
            push(4'd9, 1, 0, 0, 0, 0, 0, 2'b01, 2'b10, 2'b00, rbit(), rnd4());
        end else begin
            is_cmp  = (cmd == 4'b1010) || (cmd == 4'b1011);
            logical = (cmd == 4'b0000) || (cmd == 4'b1100);
            case (cmd)
                4'b0000: alu = 2'b10;
                4'b0010: alu = 2'b01;
                4'b1100: alu = 2'b11;
                4'b1010: alu = 2'b01;
                default: alu = 2'b00;
            endcase
            push(ins[25] ? 4'd7 : 4'd6, 0, 0, 0, 0, 0, 0, ins[25] ? 2'b01 : 2'b00, 2'b00, alu, rbit(), exec_af);
            if (ins[20] || is_cmp) m_flags = logical ? {exec_af[3:2], m_flags[1:0]} : exec_af;
            if (!is_cmp) push(4'd8, rd15, 0, 0, !rd15, 0, 0, 2'b00, 2'b00, 2'b00, rbit(), rnd4());
        end
    endfunction

    // Drive one instruction's trace; entered and left just after a rising edge.
    // If abort_st matches a cycle's state, reset is pulsed in that cycle instead.
    task automatic run_instr(input logic [31:0] ins, input int fw, input int mw,
                             input logic [3:0] exec_af, input int abort_st);
        logic [1:0] op;
        op = ins[27:26];
        build(ins, fw, mw, exec_af);
        Instr = ins;
        foreach (q[k]) begin
            MemReady = q[k].mr;
            ALUFlags = q[k].af;
            @(negedge CLK);
            check_eq($sformatf("ctl_%h_c%0d", ins, k),
                     {16'h0, State, PCWrite, IRWrite, MemWrite, RegWrite, AdrSrc, ALUSrcA,
                      ALUSrcB, ResultSrc, ALUControl},
                     {16'h0, q[k].st, q[k].pcw, q[k].irw, q[k].memw, q[k].regw, q[k].adr,
                      q[k].srca, q[k].srcb, q[k].res, q[k].alu});
            check_eq($sformatf("flags_%h_c%0d", ins, k), 32'(Flags), 32'(q[k].fl));
            if (k == 0) begin
                check_eq("immsrc", 32'(ImmSrc), (op == 2'b01) ? 32'd1 : (op == 2'b10) ? 32'd2 : 32'd0);
                check_eq("regsrc", 32'(RegSrc), {30'd0, (op == 2'b01) && !ins[20], op == 2'b10});
            end
            if (int'(q[k].st) == abort_st) begin
                MemReady = 1'b1;
                RESETn = 1'b0;
                m_flags = 4'h0;
                #1;
                check_eq("abort_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
                check_eq("abort_state", 32'(State), 32'd0);
                check_eq("abort_flags", 32'(Flags), 32'd0);
                @(posedge CLK);
                #1;
                check_eq("abort_hold", {24'd0, State, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
                RESETn = 1'b1;
                return;
            end
            @(posedge CLK);
            #1;
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        logic [3:0]  cmds [6];
        int          cls;
        cmds[0] = 4'b0000; cmds[1] = 4'b0010; cmds[2] = 4'b0100;
        cmds[3] = 4'b1100; cmds[4] = 4'b1010; cmds[5] = 4'b1011;
        ins = $urandom;
        ins[31:28] = ($urandom_range(0, 2) == 0) ? 4'($urandom_range(0, 15)) : 4'hE;
        cls = $urandom_range(0, 3);
        ins[27:26] = 2'(cls);
        if (cls == 0) ins[24:21] = cmds[$urandom_range(0, 5)];
        if ($urandom_range(0, 7) == 0) ins[15:12] = 4'hF;
        return ins;
    endfunction

    initial begin
        // Reset state with MemReady high: no strobes, FETCH, cleared flags
        RESETn = 1'b0;
        MemReady = 1'b1;
        ALUFlags = 4'hF;
        Instr = 32'hE2921005;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check_eq("rst_state", 32'(State), 32'd0);
        check_eq("rst_strobes", {28'd0, PCWrite, IRWrite, MemWrite, RegWrite}, 32'd0);
        check_eq("rst_flags", 32'(Flags), 32'd0);
        @(posedge CLK);
        #1;
        RESETn = 1'b1;
        m_flags = 4'h0;

        // ADDS R1,R2,#5 with Z produced by the ALU
        run_instr(32'hE2921005, 0, 0, 4'b0100, -1);
        @(negedge CLK);
        check_eq("adds_flags", 32'(Flags), 32'b0100);
        @(posedge CLK);
        #1;
        // LDR R0,[R1,#8] with two wait cycles on the read
        run_instr(32'hE5910008, 0, 2, 4'h0, -1);
        // STR with a fetch wait and a write wait
        run_instr(32'hE5810004, 1, 1, 4'h0, -1);
        // CMP producing Z, then BNE (skipped) and BEQ (taken)
        run_instr(32'hE3510000, 0, 0, 4'b0100, -1);
        run_instr(32'h1A000002, 0, 0, 4'h0, -1);
        run_instr(32'h0A000002, 0, 0, 4'h0, -1);
        // Reset pulse in the middle of a stalled store, then a clean LDR
        run_instr(32'hE5810004, 0, 3, 4'h0, 5);
        run_instr(32'hE5910008, 0, 0, 4'h0, -1);

        // Randomized instruction stream
        for (int n = 0; n < 200; n++) begin
            run_instr(rand_instr(), $urandom_range(0, 2), $urandom_range(0, 3), rnd4(), -1);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
